// File: rtl/wb_hyperram_arbiter.sv
// Two-master Wishbone classic arbiter in front of the single HyperRAM slave.
// Round-robin grant held for a whole cycle; a watchdog aborts a stalled slave with err.
module wb_hyperram_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_dat_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_dat_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,

    output logic [7:0]      timeout_cnt_o
);

    typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABORT0, ABORT1} state_e;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] wdog_q, wdog_d;
    logic [7:0]  timeout_cnt_q, timeout_cnt_d;

    // Signals of whichever master currently owns (or last owned) the slave.
    logic            on_m1;
    logic            g_cyc, g_stb, g_we, other_cyc;
    logic [DW/8-1:0] g_sel;
    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    state_e          release_state;

    assign on_m1     = (state_q == GNT1) || (state_q == ABORT1);
    assign g_cyc     = on_m1 ? m1_cyc_i : m0_cyc_i;
    assign g_stb     = on_m1 ? m1_stb_i : m0_stb_i;
    assign g_we      = on_m1 ? m1_we_i  : m0_we_i;
    assign g_sel     = on_m1 ? m1_sel_i : m0_sel_i;
    assign g_adr     = on_m1 ? m1_adr_i : m0_adr_i;
    assign g_dat     = on_m1 ? m1_dat_i : m0_dat_i;
    assign other_cyc = on_m1 ? m0_cyc_i : m1_cyc_i;

    // Handoff goes straight to the waiting master with no idle cycle in between.
    always_comb begin
        release_state = IDLE;
        if (other_cyc) release_state = on_m1 ? GNT0 : GNT1;
    end

    logic ack_g, err_g, in_gnt;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        wdog_d        = wdog_q;
        timeout_cnt_d = timeout_cnt_q;
        ack_g         = 1'b0;
        err_g         = 1'b0;
        in_gnt        = 1'b0;
        s_cyc_o       = 1'b0;
        s_stb_o       = 1'b0;
        s_we_o        = 1'b0;
        s_sel_o       = '0;
        s_adr_o       = '0;
        s_dat_o       = '0;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) state_d = GNT0;
                else if (m1_cyc_i)                           state_d = GNT1;
            end
            GNT0, GNT1: begin
                in_gnt  = 1'b1;
                s_cyc_o = g_cyc;
                s_stb_o = g_cyc && g_stb;
                s_we_o  = g_we;
                s_sel_o = g_sel;
                s_adr_o = g_adr;
                s_dat_o = g_dat;
                ack_g   = s_ack_i;
                if (!g_cyc) begin
                    state_d = release_state;
                end else if (g_stb && !s_ack_i) begin
                    if (wdog_q == WD_LAST) begin
                        err_g   = 1'b1;
                        state_d = on_m1 ? ABORT1 : ABORT0;
                        if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end else begin
                        wdog_d = wdog_q + 16'd1;
                    end
                end else begin
                    wdog_d = '0;
                end
            end
            ABORT0, ABORT1: begin
                if (!g_cyc) state_d = release_state;
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == GNT0) && (state_q != GNT0)) begin
            wdog_d       = '0;
            last_grant_d = 1'b0;
        end
        if ((state_d == GNT1) && (state_q != GNT1)) begin
            wdog_d       = '0;
            last_grant_d = 1'b1;
        end
    end

    assign m0_ack_o      = ack_g && !on_m1;
    assign m1_ack_o      = ack_g &&  on_m1;
    assign m0_err_o      = err_g && !on_m1;
    assign m1_err_o      = err_g &&  on_m1;
    assign m0_dat_o      = in_gnt ? s_dat_i : '0;
    assign m1_dat_o      = in_gnt ? s_dat_i : '0;
    assign timeout_cnt_o = timeout_cnt_q;

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            wdog_q        <= '0;
            timeout_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            wdog_q        <= wdog_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

endmodule
